// File: rtl/interboard_pkg.sv
// interboard_pkg: shared frame format for the board-to-board Request/Ack link.
// Used by both the transmitter and interboard_receiver so both ends agree on
// word count, field positions and message encodings.
// Configuration macro: INTERBOARD_PARITY_EN adds a fifth XOR parity word.
package interboard_pkg;

`ifdef INTERBOARD_PARITY_EN
  localparam int NUM_WORDS = 5;
`else
  localparam int NUM_WORDS = 4;
`endif

  localparam int WORD_W = 6;
  localparam int WIDX_W = $clog2(NUM_WORDS);

  // w0 = {msg_type[3:0], move_dir, 1'b0}
  localparam int W0_MSG_HI = 5;
  localparam int W0_MSG_LO = 2;
  localparam int W0_DIR    = 1;
  // w1 = {block_y[2:0], sel_len[2:0]}
  localparam int W1_Y_HI   = 5;
  localparam int W1_Y_LO   = 3;
  localparam int W1_LEN_HI = 2;
  localparam int W1_LEN_LO = 0;
  // w2 = {1'b0, block_x[4:0]}
  localparam int W2_X_HI   = 4;
  localparam int W2_X_LO   = 0;
  // w3 = card[5:0]

  localparam logic [3:0] MSG_NONE   = 4'h0;
  localparam logic [3:0] MSG_MOVE   = 4'h1;
  localparam logic [3:0] MSG_SELECT = 4'h2;
  localparam logic [3:0] MSG_CARD   = 4'h3;
  localparam logic [3:0] MSG_RST    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } rx_state_e;

endpackage

// File: rtl/interboard_receiver_sync.sv
// interboard_sync: SYNC_STAGES flop chain bringing an asynchronous level into
// the clk domain. The output only follows the chain once every stage agrees,
// so pulses shorter than the chain depth never reach the output.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   async_i in  asynchronous input level
//   sync_o  out synchronized, glitch-filtered level
module interboard_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   hold_q;
  logic                   sync_d;

  always_comb begin
    sync_d = hold_q;
    if (&chain_q)       sync_d = 1'b1;
    else if (~|chain_q) sync_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
      hold_q  <= sync_d;
    end
  end

  assign sync_o = sync_d;

endmodule

// File: rtl/interboard_receiver.sv
// interboard_receiver: receive side of the 6-bit 4-phase Request/Ack link.
// Captures one word per request, acknowledges it, and after the last word
// emits a 1-cycle interboard_en (or interboard_rst for reset frames) with
// the decoded fields. A stalled frame is aborted after TIMEOUT_CYC cycles.
// Configuration macro: INTERBOARD_PARITY_EN (5-word frames, w4 = XOR w0..w3).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   Request_in          remote request (asynchronous)
//   inter_data_in[5:0]  remote data word
//   Ack_out             acknowledge to remote board
//   interboard_en       1-cycle strobe, decoded fields valid
//   interboard_rst      1-cycle strobe, reset frame received
//   interboard_*        decoded fields (hold between frames)
//   frame_err           1-cycle strobe, frame dropped
//   busy                frame in progress
module interboard_receiver
  import interboard_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter int         TIMEOUT_CYC  = 1000000,
  parameter logic [3:0] RST_MSG_TYPE = MSG_RST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic       interboard_rst,
  output logic [3:0] interboard_msg_type,
  output logic       interboard_move_dir,
  output logic [4:0] interboard_block_x,
  output logic [2:0] interboard_block_y,
  output logic [5:0] interboard_card,
  output logic [2:0] interboard_sel_len,
  output logic       frame_err,
  output logic       busy
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(NUM_WORDS - 1);

  rx_state_e         state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_s, req_prev_q, req_edge;
  logic              cap, load, timeout_hit, parity_ok, is_rst_frame, in_done;
  logic [WORD_W-1:0] words_q [NUM_WORDS];

  logic [3:0] msg_q;
  logic       dir_q;
  logic [4:0] x_q;
  logic [2:0] y_q;
  logic [5:0] card_q;
  logic [2:0] len_q;

  interboard_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (Request_in),
    .sync_o  (req_s)
  );

  assign req_edge = req_s ^ req_prev_q;

`ifdef INTERBOARD_PARITY_EN
  logic [WORD_W-1:0] par_calc;
  always_comb begin
    par_calc = '0;
    for (int i = 0; i < NUM_WORDS - 1; i++) par_calc = par_calc ^ words_q[i];
    parity_ok = (par_calc == words_q[NUM_WORDS-1]);
  end
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    cnt_d       = '0;
    cap         = 1'b0;
    load        = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        widx_d = '0;
        if (req_s) begin
          cap     = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        cnt_d = req_edge ? '0 : cnt_q + CNT_W'(1);
        if (!req_s) begin
          if (widx_q == LAST_IDX) begin
            load    = 1'b1;
            state_d = ST_DONE;
          end else begin
            widx_d  = widx_q + WIDX_W'(1);
            state_d = ST_WAIT;
          end
        end else if (cnt_q == CNT_LAST && !req_edge) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = req_edge ? '0 : cnt_q + CNT_W'(1);
        if (req_s) begin
          cap     = 1'b1;
          state_d = ST_ACK;
        end else if (cnt_q == CNT_LAST && !req_edge) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_DONE: begin
        widx_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      widx_q     <= '0;
      cnt_q      <= '0;
      req_prev_q <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= '0;
      msg_q      <= '0;
      dir_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      card_q     <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      cnt_q      <= cnt_d;
      req_prev_q <= req_s;
      if (cap) words_q[widx_q] <= inter_data_in;
      // Fields load on entry to DONE; a frame with bad parity leaves them untouched.
      if (load && parity_ok) begin
        msg_q  <= words_q[0][W0_MSG_HI:W0_MSG_LO];
        dir_q  <= words_q[0][W0_DIR];
        y_q    <= words_q[1][W1_Y_HI:W1_Y_LO];
        len_q  <= words_q[1][W1_LEN_HI:W1_LEN_LO];
        x_q    <= words_q[2][W2_X_HI:W2_X_LO];
        card_q <= words_q[3];
      end
    end
  end

  assign in_done      = (state_q == ST_DONE);
  assign is_rst_frame = (words_q[0][W0_MSG_HI:W0_MSG_LO] == RST_MSG_TYPE);

  assign Ack_out             = (state_q == ST_ACK);
  assign busy                = (state_q == ST_ACK) || (state_q == ST_WAIT);
  assign interboard_en       = in_done && parity_ok && !is_rst_frame;
  assign interboard_rst      = in_done && parity_ok && is_rst_frame;
  assign frame_err           = timeout_hit || (in_done && !parity_ok);
  assign interboard_msg_type = msg_q;
  assign interboard_move_dir = dir_q;
  assign interboard_block_x  = x_q;
  assign interboard_block_y  = y_q;
  assign interboard_card     = card_q;
  assign interboard_sel_len  = len_q;

endmodule
